// File: rtl/mem_req_pkg.sv
// Shared types and constants for the memory-stage request controller.
package mem_req_pkg;

  localparam int MEM_W           = 16;
  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_perf_cnt.sv
// Three saturating performance counters (accesses, cache hits, stall cycles).
module mem_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_acc,
  input  logic             inc_hit,
  input  logic             inc_stall,
  output logic [CNT_W-1:0] perf_acc,
  output logic [CNT_W-1:0] perf_hit,
  output logic [CNT_W-1:0] perf_stall
);

  // Each counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_acc   <= '0;
      perf_hit   <= '0;
      perf_stall <= '0;
    end else begin
      if (inc_acc && (perf_acc != '1))
        perf_acc <= perf_acc + 1'b1;
      if (inc_hit && (perf_hit != '1))
        perf_hit <= perf_hit + 1'b1;
      if (inc_stall && (perf_stall != '1))
        perf_stall <= perf_stall + 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory-stage request controller between the pipeline and mem_system.
// Define MEM_PERF_CNT_EN to build the perf_acc/perf_hit/perf_stall counters.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MEM_W-1:0] p_addr,
  input  logic [MEM_W-1:0] p_data_in,
  input  logic             p_rd,
  input  logic             p_wr,
  input  logic             p_halt,
  output logic [MEM_W-1:0] p_data_out,
  output logic             p_stall,
  output logic             p_err,
  output logic [MEM_W-1:0] m_addr,
  output logic [MEM_W-1:0] m_data_in,
  output logic             m_rd,
  output logic             m_wr,
  output logic             m_createdump,
  input  logic [MEM_W-1:0] m_data_out,
  input  logic             m_done,
  input  logic             m_stall,
  input  logic             m_cachehit,
  input  logic             m_err,
  output logic [CNT_W-1:0] perf_acc,
  output logic [CNT_W-1:0] perf_hit,
  output logic [CNT_W-1:0] perf_stall
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_nxt;
  logic [MEM_W-1:0] addr_q, wdata_q, rdata_q;
  logic             is_load_q;
  logic [TW-1:0]    tcnt;
  logic             req, illegal, issue, complete, complete_load;

  assign m_createdump = p_halt;

  // Next state and all request-side outputs; IDLE issues, BUSY waits for Done.
  always_comb begin
    req           = p_rd | p_wr;
    illegal       = req & ((p_rd & p_wr) | p_addr[0]);
    state_nxt     = state;
    m_rd          = 1'b0;
    m_wr          = 1'b0;
    m_addr        = addr_q;
    m_data_in     = wdata_q;
    p_stall       = 1'b0;
    p_err         = 1'b0;
    issue         = 1'b0;
    complete      = 1'b0;
    complete_load = 1'b0;
    case (state)
      IDLE: begin
        if (illegal) begin
          p_err = 1'b1;
        end else if (req) begin
          if (m_stall) begin
            p_stall = 1'b1;
          end else begin
            issue     = 1'b1;
            m_rd      = p_rd;
            m_wr      = p_wr;
            m_addr    = p_addr;
            m_data_in = p_data_in;
            if (m_done) begin
              complete      = 1'b1;
              complete_load = p_rd;
            end else begin
              p_stall   = 1'b1;
              state_nxt = BUSY;
            end
          end
        end
      end
      BUSY: begin
        if (m_done) begin
          complete      = 1'b1;
          complete_load = is_load_q;
          state_nxt     = IDLE;
        end else begin
          p_stall = 1'b1;
          if (tcnt == TW'(TIMEOUT_CYCLES - 1))
            state_nxt = ERR;
        end
      end
      ERR: begin
        p_err = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (m_err)
      state_nxt = ERR;
    p_data_out = complete_load ? m_data_out : rdata_q;
  end

  // Latch the issued request so mem_system sees stable Addr/DataIn until Done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      is_load_q <= 1'b0;
      tcnt      <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        addr_q    <= p_addr;
        wdata_q   <= p_data_in;
        is_load_q <= p_rd;
      end
      if (complete_load)
        rdata_q <= m_data_out;
      if (state == BUSY)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;
    end
  end

`ifdef MEM_PERF_CNT_EN
  mem_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk       (clk),
    .rst       (rst),
    .inc_acc   (issue),
    .inc_hit   (complete & m_cachehit),
    .inc_stall (p_stall),
    .perf_acc  (perf_acc),
    .perf_hit  (perf_hit),
    .perf_stall(perf_stall)
  );
`else
  logic perf_unused;
  assign perf_unused = m_cachehit;
  assign perf_acc    = '0;
  assign perf_hit    = '0;
  assign perf_stall  = '0;
`endif

endmodule
